// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the hazard/EX logic and the fetch sequencer.
// Optional perf counters exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_sequencer_if #(
  parameter int PC_SIZE = 32
);
  logic               branch_taken;
  logic [PC_SIZE-1:0] branch_target;
  logic               load_use_hazard;
  logic               halt_detect;
  logic               resume;
  logic               PCScr;
  logic [PC_SIZE-1:0] PC_jump;
  logic               pc_write_en;
  logic               ifid_write_en;
  logic               ifid_flush;
  logic [2:0]         fetch_state;
  logic               stall_timeout;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_stall_cycles;
  logic [31:0]        perf_redirects;
`endif

  modport master (
    output branch_taken, branch_target, load_use_hazard, halt_detect, resume,
    input  PCScr, PC_jump, pc_write_en, ifid_write_en, ifid_flush,
    input  fetch_state, stall_timeout
`ifdef FETCH_PERF_CNT_EN
    , input perf_stall_cycles, perf_redirects
`endif
  );

  modport slave (
    input  branch_taken, branch_target, load_use_hazard, halt_detect, resume,
    output PCScr, PC_jump, pc_write_en, ifid_write_en, ifid_flush,
    output fetch_state, stall_timeout
`ifdef FETCH_PERF_CNT_EN
    , output perf_stall_cycles, perf_redirects
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage control FSM: merges branch redirects, load-use stalls and
// halt/resume into PC mux select and PC / IF-ID enables and flush.
// Optional macro FETCH_PERF_CNT_EN adds stall-cycle and redirect counters.
module fetch_sequencer #(
  parameter int PC_SIZE       = 32,
  parameter int BOOT_CYCLES   = 2,
  parameter int FLUSH_DEPTH   = 1,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  localparam int MAX_AB = (BOOT_CYCLES > FLUSH_DEPTH) ? BOOT_CYCLES : FLUSH_DEPTH;
  localparam int MAX_P  = (MAX_AB > STALL_TIMEOUT) ? MAX_AB : STALL_TIMEOUT;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] BOOT_LAST  = CW'(BOOT_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_TIMEOUT - 1);
  localparam logic [CW-1:0] STALL_MAX  = CW'(STALL_TIMEOUT);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STALL    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [CW-1:0]      r_stall_cnt;
  logic [PC_SIZE-1:0] r_target_q, w_target_nxt;
  logic               r_stall_timeout;
  logic               w_redirect_evt;
  logic               w_pcscr, w_pc_we, w_ifid_we, w_flush;

  // Next-state: one event acted on per edge, branch > load-use > halt
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_target_nxt   = r_target_q;
    w_redirect_evt = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        if (r_cnt == BOOT_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_RUN, ST_STALL: begin
        if (bus.branch_taken) begin
          w_state_nxt    = ST_REDIRECT;
          w_cnt_nxt      = '0;
          w_target_nxt   = bus.branch_target;
          w_redirect_evt = 1'b1;
        end else if (bus.load_use_hazard) begin
          w_state_nxt = ST_STALL;
        end else if (bus.halt_detect) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (bus.branch_taken) begin
          w_cnt_nxt      = '0;
          w_target_nxt   = bus.branch_target;
          w_redirect_evt = 1'b1;
        end else if (r_cnt == FLUSH_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HALT: begin
        if (bus.resume) w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Moore output decode from registered state and counter
  always_comb begin
    w_pcscr   = 1'b0;
    w_pc_we   = 1'b0;
    w_ifid_we = 1'b0;
    w_flush   = 1'b1;
    unique case (r_state)
      ST_RUN: begin
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
        w_flush   = 1'b0;
      end
      ST_STALL: begin
        w_flush = 1'b0;
      end
      ST_REDIRECT: begin
        w_pcscr   = (r_cnt == '0);
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
      end
      default: begin
        w_flush = 1'b1;
      end
    endcase
  end

  // State, redirect counter and captured target
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_cnt      <= '0;
      r_target_q <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_target_q <= w_target_nxt;
    end
  end

  // Stall watchdog: flag rises at the edge that completes the
  // STALL_TIMEOUT-th consecutive STALL cycle, then stays until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else if (r_state == ST_STALL) begin
      if (r_stall_cnt != STALL_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (r_stall_cnt == STALL_LAST) r_stall_timeout <= 1'b1;
    end else begin
      r_stall_cnt <= '0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_redir;

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (r_state == ST_STALL && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redirect_evt && r_perf_redir != '1) r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_redirects    = r_perf_redir;
`endif

  assign bus.PCScr         = w_pcscr;
  assign bus.PC_jump       = r_target_q;
  assign bus.pc_write_en   = w_pc_we;
  assign bus.ifid_write_en = w_ifid_we;
  assign bus.ifid_flush    = w_flush;
  assign bus.fetch_state   = r_state;
  assign bus.stall_timeout = r_stall_timeout;

endmodule
